sat_accumulator: RTL

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

---
 rtl/acc_pkg.sv | 19 +
 rtl/carry_bypass_adder.sv | 58 +++++
 rtl/sat_accumulator.sv | 128 ++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the saturating packet accumulator: FSM state
// encoding and the default datapath widths.
package acc_pkg;

  // Default operand/accumulator width and beat-counter width.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  // Accumulator control states.
  //   ST_IDLE  : no packet in progress, ready for the first beat
  //   ST_ACCUM : at least one non-last beat absorbed
  //   ST_HOLD  : final result presented, waiting for the downstream handshake
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

endpackage : acc_pkg

// File: rtl/carry_bypass_adder.sv
// Carry-bypass (carry-skip) adder. Bits are grouped into BLOCK-wide ripple
// blocks; when every bit of a block propagates, the block's carry-in is
// forwarded directly to the next block. Also reports signed overflow.
module carry_bypass_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;

  logic carry;    // carry travelling between blocks
  logic blk_cin;  // carry entering the current block
  logic rip;      // ripple carry inside the current block
  logic p;        // propagate of the current bit
  logic p_all;    // every bit of the current block propagates
  logic c_msb;    // carry into the sign bit, for overflow detection
  int   idx;

  // Ripple within each block, skip across a fully-propagating block.
  // NOTE: blocking assignments here are deliberate -- carry, rip and p_all
  // are evaluated in order as the loop unrolls, like wires in a chain.
  always_comb begin
    sum     = '0;
    carry   = cin;
    blk_cin = 1'b0;
    rip     = 1'b0;
    p       = 1'b0;
    p_all   = 1'b0;
    c_msb   = 1'b0;
    idx     = 0;
    for (int blk = 0; blk < NBLK; blk++) begin
      blk_cin = carry;
      rip     = carry;
      p_all   = 1'b1;
      for (int k = 0; k < BLOCK; k++) begin
        idx = blk * BLOCK + k;
        if (idx < WIDTH) begin
          p = a[idx] ^ b[idx];
          if (idx == WIDTH - 1) c_msb = rip;
          sum[idx] = p ^ rip;
          rip      = (a[idx] & b[idx]) | (p & rip);
          p_all    = p_all & p;
        end
      end
      carry = p_all ? blk_cin : rip;
    end
    cout     = carry;
    overflow = c_msb ^ carry;
  end

endmodule : carry_bypass_adder

// File: rtl/sat_accumulator.sv
// Packet accumulator: sums the signed beats of a valid/ready packet, with
// optional saturation on signed overflow, a sticky overflow flag and a
// saturating beat counter. The result is held until the downstream accepts it.
module sat_accumulator
  import acc_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             cout_unused;
  logic [WIDTH-1:0] acc_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             beat;

  // Running sum plus the incoming operand; the carry-out is not needed.
  carry_bypass_adder #(
    .WIDTH (WIDTH),
    .BLOCK (4)
  ) u_adder (
    .a        (acc_q),
    .b        (in_data),
    .cin      (1'b0),
    .sum      (add_sum),
    .cout     (cout_unused),
    .overflow (add_ovf)
  );

  // run_q holds in_ready low while in reset and for the rest of that cycle.
  assign in_ready  = run_q && (state_q != ST_HOLD);
  assign out_valid = (state_q == ST_HOLD);
  assign beat      = in_valid && in_ready;

  assign out_sum      = acc_q;
  assign out_overflow = ovf_q;
  assign out_count    = cnt_q;

  // Clamp toward the operand's sign on overflow, otherwise take the raw sum.
  always_comb begin
    acc_next = add_sum;
    if (SATURATE && add_ovf) acc_next = in_data[WIDTH-1] ? SAT_MIN : SAT_MAX;
  end

  // Beat counter increment that sticks at its maximum.
  always_comb begin
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and datapath update for the packet FSM.
  // NOTE: every signal is given a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_ACCUM: begin
        if (beat) begin
          acc_d   = acc_next;
          ovf_d   = ovf_q | add_ovf;
          cnt_d   = cnt_inc;
          state_d = in_last ? ST_HOLD : ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // NOTE: reset is asynchronous, so it is in the sensitivity list and clears
  // the state without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Input-ready enable: released on the first clock edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

endmodule : sat_accumulator
